spi_xfer_engine: RTL and testbench

//  Byte-level SPI master sequencer placed directly upstream of wb_bus. Converts one

---
 rtl/spi_xfer_engine_pkg.sv | 29 ++
 rtl/spi_xfer_engine_if.sv | 14 +
 rtl/spi_xfer_engine_wb_access.sv | 63 ++++++
 rtl/spi_xfer_engine.sv | 173 +++++++++++++++++
 tb/tb_spi_xfer_engine.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_engine_pkg.sv
// Shared definitions for the SPI transfer engine: SB_SPI register offsets
// (low address nibble), status bit indices, fixed register values and the
// bus request record passed from the sequencer to the bus access unit.
package spi_xfer_engine_pkg;

  localparam logic [3:0] OFS_CR1  = 4'h9;
  localparam logic [3:0] OFS_CR2  = 4'hA;
  localparam logic [3:0] OFS_BR   = 4'hB;
  localparam logic [3:0] OFS_SR   = 4'hC;
  localparam logic [3:0] OFS_TXDR = 4'hD;
  localparam logic [3:0] OFS_RXDR = 4'hE;
  localparam logic [3:0] OFS_CSR  = 4'hF;

  localparam int SR_TIP  = 7;
  localparam int SR_BUSY = 6;
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;

  localparam logic [7:0] CR1_EN  = 8'h80;
  localparam logic [7:0] CSR_ON  = 8'hFE;
  localparam logic [7:0] CSR_OFF = 8'hFF;

  typedef struct packed {
    logic       we;
    logic [3:0] ofs;
    logic [7:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/spi_xfer_engine_if.sv
// System-bus signals between the transfer engine and wb_bus.
//  cs/we/addr/din : access request, driven by the master
//  dout/rdy       : read data and completion strobe, driven by the slave
interface spi_xfer_engine_if;
  logic       cs;
  logic       we;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rdy;

  modport master (output cs, we, addr, din, input dout, rdy);
  modport slave  (input cs, we, addr, din, output dout, rdy);
endinterface

// File: rtl/spi_xfer_engine_wb_access.sv
// Single bus access unit. Accepts a request (req_i with we/addr/wdata) while
// the bus is idle, holds cs/we/addr/din stable until rdy, then signals ack_o
// in the rdy cycle with rdata_o carrying bus dout for that cycle.
//  clk, rst          : clock, async active-high reset
//  req_i/we_i/addr_i/wdata_i : access request (level, held until ack_o)
//  ack_o, rdata_o    : completion and read data (combinational on rdy)
//  bus               : master side of the wb_bus interface
module spi_xfer_engine_wb_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  spi_xfer_engine_if.master bus
);

  logic       cs_q, cs_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;

  // A new access is only accepted while cs_q is low; since cs_q drops on the
  // rdy edge, at least one idle cycle always separates two accesses.
  always_comb begin
    cs_d   = cs_q;
    we_d   = we_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (cs_q) begin
      if (bus.rdy) cs_d = 1'b0;
    end else if (req_i) begin
      cs_d   = 1'b1;
      we_d   = we_i;
      addr_d = addr_i;
      din_d  = wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= 8'h00;
      din_q  <= 8'h00;
    end else begin
      cs_q   <= cs_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign ack_o    = cs_q & bus.rdy;
  assign rdata_o  = bus.dout;
  assign bus.cs   = cs_q;
  assign bus.we   = we_q;
  assign bus.addr = addr_q;
  assign bus.din  = din_q;

endmodule

// File: rtl/spi_xfer_engine.sv
// Byte-level SPI master sequencer in front of wb_bus / SB_SPI. One start
// pulse runs: optional one-time init (CR1, CR2, BR), optional CS assert,
// TRDY poll, TXDR write, RRDY poll, RXDR read, optional CS release.
//  clk, rst     : clock, async active-high reset
//  start_i      : transfer request pulse (ignored unless idle)
//  tx_data_i    : byte to send, cs_hold_i : keep CS asserted afterwards
//  busy_o       : transfer in progress
//  done_o       : one-cycle end-of-transfer pulse
//  rx_data_o    : received byte, err_o : poll timeout flag
//  bus          : master side of the wb_bus interface
module spi_xfer_engine
  import spi_xfer_engine_pkg::*;
#(
  parameter logic [3:0] ADDR74     = 4'h0,
  parameter logic [7:0] BR_VAL     = 8'h05,
  parameter logic [7:0] CR2_VAL    = 8'hC0,
  parameter int         POLL_LIMIT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  input  logic       cs_hold_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_data_o,
  output logic       err_o,
  spi_xfer_engine_if.master bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_CR1  = 4'd1;
  localparam logic [3:0] S_INIT_CR2  = 4'd2;
  localparam logic [3:0] S_INIT_BR   = 4'd3;
  localparam logic [3:0] S_CS_ON     = 4'd4;
  localparam logic [3:0] S_POLL_TRDY = 4'd5;
  localparam logic [3:0] S_WR_TX     = 4'd6;
  localparam logic [3:0] S_POLL_RRDY = 4'd7;
  localparam logic [3:0] S_RD_RX     = 4'd8;
  localparam logic [3:0] S_CS_OFF    = 4'd9;
  localparam logic [3:0] S_TIMEOUT   = 4'd10;
  localparam logic [3:0] S_DONE      = 4'd11;

  localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic       hold_q, hold_d;
  logic       init_q, init_d;
  logic       csa_q, csa_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic       err_q, err_d;

  bus_req_t   rq;
  logic       req, ack;
  logic [7:0] rdata;
  logic       is_poll, poll_hit;

  // Bus request implied by the current state.
  always_comb begin
    req = 1'b1;
    rq  = '{1'b1, OFS_CSR, CSR_OFF};
    unique case (state_q)
      S_INIT_CR1:               rq = '{1'b1, OFS_CR1, CR1_EN};
      S_INIT_CR2:               rq = '{1'b1, OFS_CR2, CR2_VAL};
      S_INIT_BR:                rq = '{1'b1, OFS_BR, BR_VAL};
      S_CS_ON:                  rq = '{1'b1, OFS_CSR, CSR_ON};
      S_POLL_TRDY, S_POLL_RRDY: rq = '{1'b0, OFS_SR, 8'h00};
      S_WR_TX:                  rq = '{1'b1, OFS_TXDR, tx_q};
      S_RD_RX:                  rq = '{1'b0, OFS_RXDR, 8'h00};
      S_CS_OFF, S_TIMEOUT:      rq = '{1'b1, OFS_CSR, CSR_OFF};
      default:                  req = 1'b0;
    endcase
  end

  spi_xfer_engine_wb_access u_acc (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .we_i    (rq.we),
    .addr_i  ({ADDR74, rq.ofs}),
    .wdata_i (rq.wdata),
    .ack_o   (ack),
    .rdata_o (rdata),
    .bus     (bus)
  );

  assign is_poll  = (state_q == S_POLL_TRDY) || (state_q == S_POLL_RRDY);
  assign poll_hit = (state_q == S_POLL_TRDY) ? rdata[SR_TRDY] : rdata[SR_RRDY];

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    hold_d  = hold_q;
    init_d  = init_q;
    csa_d   = csa_q;
    rx_d    = rx_q;
    err_d   = err_q;
    // Counter restarts whenever we are outside a poll state, so each poll
    // phase begins at zero.
    cnt_d   = is_poll ? cnt_q : 10'd0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        tx_d   = tx_data_i;
        hold_d = cs_hold_i;
        err_d  = 1'b0;
        state_d = !init_q ? S_INIT_CR1 : (!csa_q ? S_CS_ON : S_POLL_TRDY);
      end
      S_INIT_CR1: if (ack) state_d = S_INIT_CR2;
      S_INIT_CR2: if (ack) state_d = S_INIT_BR;
      S_INIT_BR: if (ack) begin
        init_d  = 1'b1;
        state_d = !csa_q ? S_CS_ON : S_POLL_TRDY;
      end
      S_CS_ON: if (ack) begin
        csa_d   = 1'b1;
        state_d = S_POLL_TRDY;
      end
      S_POLL_TRDY, S_POLL_RRDY: if (ack) begin
        if (poll_hit)                state_d = (state_q == S_POLL_TRDY) ? S_WR_TX : S_RD_RX;
        else if (cnt_q == POLL_LAST) state_d = S_TIMEOUT;
        else                         cnt_d = cnt_q + 10'd1;
      end
      S_WR_TX: if (ack) state_d = S_POLL_RRDY;
      S_RD_RX: if (ack) begin
        rx_d    = rdata;
        state_d = hold_q ? S_DONE : S_CS_OFF;
      end
      S_CS_OFF: if (ack) begin
        csa_d   = 1'b0;
        state_d = S_DONE;
      end
      // Timeout drops CS and forces a fresh init on the next transfer.
      S_TIMEOUT: if (ack) begin
        csa_d   = 1'b0;
        init_d  = 1'b0;
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= 8'h00;
      hold_q  <= 1'b0;
      init_q  <= 1'b0;
      csa_q   <= 1'b0;
      cnt_q   <= 10'd0;
      rx_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      hold_q  <= hold_d;
      init_q  <= init_d;
      csa_q   <= csa_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign rx_data_o = rx_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
module tb_spi_xfer_engine;

  localparam logic [3:0] A = 4'h2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] tx = 8'h00;
  logic hold = 1'b0;
  logic busy, done, err;
  logic [7:0] rx;

  spi_xfer_engine_if bus ();

  spi_xfer_engine #(.ADDR74(A)) dut (
    .clk(clk), .rst(rst), .start_i(start), .tx_data_i(tx), .cs_hold_i(hold),
    .busy_o(busy), .done_o(done), .rx_data_o(rx), .err_o(err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [7:0] data; } acc_t;
  typedef struct {
    logic [7:0] tx; logic hold; int dly; int lag; logic blk;
    logic x_init, x_cson, x_tx, x_csoff;
    int x_sr; logic [7:0] x_rx; logic x_err;
  } vec_t;

  acc_t exp_q[$];
  int pass_cnt = 0, total_cnt = 0;

  // slave configuration (written by the test only)
  int cur_dly = 0, cur_lag = 0;
  logic cur_blk = 1'b0;
  // slave-owned state and counters
  int wcnt = 0, lag_left = 0, sr_cnt = 0, tx_cnt = 0, done_cnt = 0, unstable = 0;
  logic rx_pend = 1'b0;
  logic [7:0] rxdr = 8'h00, st_addr = 8'h00, st_din = 8'h00;
  logic st_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // SB_SPI model behind wb_bus: loops TXDR back to RXDR, RRDY shows after
  // cur_lag extra SR reads, TRDY forced low when cur_blk is set.
  always @(negedge clk) begin
    acc_t e;
    if (done) done_cnt++;
    if (rst) begin
      bus.rdy = 1'b0; bus.dout = 8'h00; wcnt = 0; rx_pend = 1'b0;
    end else if (bus.rdy) begin
      bus.rdy = 1'b0;
    end else if (bus.cs) begin
      if (wcnt == 0) begin
        st_addr = bus.addr; st_we = bus.we; st_din = bus.din;
      end else if (bus.addr !== st_addr || bus.we !== st_we || bus.din !== st_din) begin
        unstable++;
      end
      if (wcnt == cur_dly) begin
        wcnt = 0;
        bus.rdy = 1'b1;
        if (bus.we) begin
          if (exp_q.size() == 0) chk("unexpected_wr", {bus.addr, bus.din}, 16'h0);
          else begin
            e = exp_q.pop_front();
            chk("bus_wr", {bus.addr, bus.din}, {e.addr, e.data});
          end
          if (bus.addr == {A, 4'hD}) begin
            rxdr = bus.din; rx_pend = 1'b1; lag_left = cur_lag; tx_cnt++;
          end
        end else if (bus.addr == {A, 4'hC}) begin
          sr_cnt++;
          bus.dout = (cur_blk ? 8'h00 : 8'h10) | ((rx_pend && lag_left == 0) ? 8'h08 : 8'h00);
          if (rx_pend && lag_left > 0) lag_left--;
        end else if (bus.addr == {A, 4'hE}) begin
          bus.dout = rxdr; rx_pend = 1'b0;
        end else begin
          bus.dout = 8'h00;
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
    acc_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_vec(input vec_t v);
    if (v.x_init) begin
      push_exp({A, 4'h9}, 8'h80); push_exp({A, 4'hA}, 8'hC0); push_exp({A, 4'hB}, 8'h05);
    end
    if (v.x_cson)  push_exp({A, 4'hF}, 8'hFE);
    if (v.x_tx)    push_exp({A, 4'hD}, v.tx);
    if (v.x_csoff) push_exp({A, 4'hF}, 8'hFF);
  endtask

  task automatic pulse_start(input logic [7:0] d, input logic h);
    start = 1'b1; tx = d; hold = h;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, sr0, dn0, us0;
    cur_dly = v.dly; cur_lag = v.lag; cur_blk = v.blk;
    sr0 = sr_cnt; dn0 = done_cnt; us0 = unstable;
    push_vec(v);
    @(negedge clk);
    pulse_start(v.tx, v.hold);
    chk($sformatf("v%0d_busy", idx), busy, 1);
    cyc = 0;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    chk($sformatf("v%0d_done_seen", idx), done, 1);
    if (idx == 0) chk("v0_latency_le40", (cyc <= 40), 1);
    chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
    chk($sformatf("v%0d_rx", idx), rx, v.x_rx);
    chk($sformatf("v%0d_err", idx), err, v.x_err);
    chk($sformatf("v%0d_sr_reads", idx), sr_cnt - sr0, v.x_sr);
    chk($sformatf("v%0d_wr_left", idx), exp_q.size(), 0);
    @(negedge clk);
    chk($sformatf("v%0d_done_1cyc", idx), done, 0);
    chk($sformatf("v%0d_done_cnt", idx), done_cnt - dn0, 1);
    chk($sformatf("v%0d_stable", idx), unstable - us0, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t rv;
    int cyc, tx0, dn0;
    vecs[0] = '{8'hA5, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2,    8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4,    8'h3C, 1'b0};
    vecs[2] = '{8'hC3, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2,    8'hC3, 1'b0};
    vecs[3] = '{8'h77, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1023, 8'hC3, 1'b1};
    vecs[4] = '{8'hA5, 1'b0, 3, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3,    8'hA5, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5,    8'h96, 1'b0};
    vecs[6] = '{8'h69, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2,    8'h69, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_rx", rx, 0);     chk("rst_cs", bus.cs, 0); chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0); chk("rst_din", bus.din, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // start while busy is dropped; start during the DONE cycle is dropped
    cur_dly = 0; cur_lag = 2; cur_blk = 1'b0;
    tx0 = tx_cnt; dn0 = done_cnt;
    push_exp({A, 4'hF}, 8'hFE); push_exp({A, 4'hD}, 8'h11); push_exp({A, 4'hF}, 8'hFF);
    pulse_start(8'h11, 1'b0);
    repeat (5) @(negedge clk);
    chk("t4_busy_mid", busy, 1);
    pulse_start(8'h22, 1'b1);
    cyc = 0;
    while (!done && cyc < 500) begin @(negedge clk); cyc++; end
    chk("t4_done_seen", done, 1);
    pulse_start(8'h33, 1'b0);
    repeat (6) @(negedge clk);
    chk("t4_idle_after", busy, 0);
    chk("t4_tx_writes", tx_cnt - tx0, 1);
    chk("t4_done_cnt", done_cnt - dn0, 1);
    chk("t4_rx", rx, 8'h11);
    chk("t4_wr_left", exp_q.size(), 0);

    // reset asserted while polling RRDY
    cur_lag = 100;
    tx0 = tx_cnt;
    push_exp({A, 4'hF}, 8'hFE); push_exp({A, 4'hD}, 8'h44);
    pulse_start(8'h44, 1'b0);
    cyc = 0;
    while (tx_cnt == tx0 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("t5_tx_written", tx_cnt - tx0, 1);
    @(negedge clk);
    cyc = 0;
    while (!bus.cs && cyc < 50) begin @(negedge clk); cyc++; end
    chk("t5_cs_before_rst", bus.cs, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_cs_dropped", bus.cs, 0);
    chk("t5_busy_dropped", busy, 0);
    chk("t5_done_low", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t5_rx_cleared", rx, 0);
    chk("t5_wr_left", exp_q.size(), 0);
    rv = '{8'hE7, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'hE7, 1'b0};
    run_vec(7, rv);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
